// File: rtl/hazard_pkg.sv
// Shared types for the data-hazard scoreboard: entry payload, regfile forward code,
// and the source/entry match rule.
package hazard_pkg;

  localparam int unsigned REG_IDX_MAX_W   = 8;
  localparam int unsigned FWD_SEL_REGFILE = 0;

  typedef logic [REG_IDX_MAX_W-1:0] reg_idx_t;

  // Register indices are zero-extended into a fixed-width dst field.
  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
    logic     wrt;
    logic     load;
  } sb_entry_t;

  function automatic logic src_matches(input sb_entry_t e,
                                       input reg_idx_t  src,
                                       input logic      src_used,
                                       input logic      zero_hw);
    return src_used && e.valid && e.wrt && (e.dst == src) &&
           !(zero_hw && (src == '0));
  endfunction

endpackage

// File: rtl/scoreboard_entry_match.sv
// Compares one DEC source against one in-flight entry; reports a match and whether it blocks.
// Blocking narrows to not-yet-ready loads when FORWARDING_EN is defined.
module scoreboard_entry_match
  import hazard_pkg::*;
#(
  parameter int unsigned ENTRY_IDX          = 0,
  parameter int unsigned LOAD_READY_STAGE   = 1,
  parameter int unsigned ZERO_REG_HARDWIRED = 0
) (
  input  sb_entry_t entry_i,
  input  reg_idx_t  src_i,
  input  logic      src_used_i,
  output logic      match_c_o,
  output logic      block_c_o
);

`ifdef FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam logic ZERO_HW        = (ZERO_REG_HARDWIRED != 0);
  localparam logic LOAD_NOT_READY = (ENTRY_IDX < LOAD_READY_STAGE);

  assign match_c_o = src_matches(entry_i, src_i, src_used_i, ZERO_HW);

  // Without forwarding every match blocks; with it, only a load still short of its ready stage.
  assign block_c_o = match_c_o && (!FWD_EN || (entry_i.load && LOAD_NOT_READY));

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit beside DEC: shift-register scoreboard of EX..WB destinations,
// zero-cycle stall decision and optional forward selects (macro FORWARDING_EN).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned PIPE_DEPTH          = 3,
  parameter int unsigned LOAD_READY_STAGE    = 1,
  parameter int unsigned ZERO_REG_HARDWIRED  = 0,
  parameter int unsigned STALL_CNT_BITS      = 16,
  parameter int unsigned FWD_SEL_BITS        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_src1_used,
  input  logic                           dec_src2_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst,
  input  logic                           dec_reg_wrt_en,
  input  logic                           dec_is_load,
  input  logic                           flush,
  input  logic                           hold,
  output logic                           stall,
  output logic [FWD_SEL_BITS-1:0]        fwd_sel1,
  output logic [FWD_SEL_BITS-1:0]        fwd_sel2,
  output logic [PIPE_DEPTH-1:0]          inflight_valid,
  output logic [STALL_CNT_BITS-1:0]      stall_count
);

`ifdef FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  sb_entry_t [PIPE_DEPTH-1:0] entry_q, entry_d;
  logic [STALL_CNT_BITS-1:0]  stall_cnt_q, stall_cnt_d;

  logic [PIPE_DEPTH-1:0] match1_c, block1_c, match2_c, block2_c;
  logic [FWD_SEL_BITS-1:0] sel1_c, sel2_c;
  logic stall_c, issue_c;

  reg_idx_t src1_ext, src2_ext, dst_ext;

  assign src1_ext = REG_IDX_MAX_W'(dec_src1);
  assign src2_ext = REG_IDX_MAX_W'(dec_src2);
  assign dst_ext  = REG_IDX_MAX_W'(dec_dst);

  // Two comparators per tracked stage, one per DEC source.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_entry
    scoreboard_entry_match #(
      .ENTRY_IDX          (k),
      .LOAD_READY_STAGE   (LOAD_READY_STAGE),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_src1 (
      .entry_i    (entry_q[k]),
      .src_i      (src1_ext),
      .src_used_i (dec_src1_used),
      .match_c_o  (match1_c[k]),
      .block_c_o  (block1_c[k])
    );

    scoreboard_entry_match #(
      .ENTRY_IDX          (k),
      .LOAD_READY_STAGE   (LOAD_READY_STAGE),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_src2 (
      .entry_i    (entry_q[k]),
      .src_i      (src2_ext),
      .src_used_i (dec_src2_used),
      .match_c_o  (match2_c[k]),
      .block_c_o  (block2_c[k])
    );
  end

  // flush kills the DEC instruction, so it can never be the one stalling.
  assign stall_c = dec_valid && !flush && (|(block1_c | block2_c));
  assign issue_c = dec_valid && !stall_c && !flush;

  // Youngest matching entry wins: scan oldest to youngest so the lowest index lands last.
  always_comb begin
    sel1_c = FWD_SEL_BITS'(FWD_SEL_REGFILE);
    sel2_c = FWD_SEL_BITS'(FWD_SEL_REGFILE);
    for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
      if (match1_c[k]) sel1_c = FWD_SEL_BITS'(k + 1);
      if (match2_c[k]) sel2_c = FWD_SEL_BITS'(k + 1);
    end
  end

  always_comb begin
    entry_d     = entry_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        entry_d[k] = entry_q[k-1];
      end
      entry_d[0] = '0;
      if (issue_c) begin
        entry_d[0].valid = 1'b1;
        entry_d[0].dst   = dst_ext;
        entry_d[0].wrt   = dec_reg_wrt_en;
        entry_d[0].load  = dec_is_load;
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    inflight_valid = '0;
    for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
      inflight_valid[k] = entry_q[k].valid;
    end
  end

  assign stall       = stall_c;
  assign fwd_sel1    = FWD_EN ? sel1_c : FWD_SEL_BITS'(FWD_SEL_REGFILE);
  assign fwd_sel2    = FWD_EN ? sel2_c : FWD_SEL_BITS'(FWD_SEL_REGFILE);
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations switch on FORWARDING_EN.
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
  localparam int         N_RAW     = 0;
  localparam int         N_LU      = 1;
  localparam int         N_PRIO    = 0;
  localparam logic [1:0] FW_RAW    = 2'd1;
  localparam logic [1:0] FW_LU     = 2'd2;
  localparam logic [1:0] FW_PRIO   = 2'd1;
  localparam logic [3:0] SAT_8     = 4'd4;
  localparam logic [15:0] MAIN_68  = 16'd34;
`else
  localparam int         N_RAW     = 3;
  localparam int         N_LU      = 3;
  localparam int         N_PRIO    = 1;
  localparam logic [1:0] FW_RAW    = 2'd0;
  localparam logic [1:0] FW_LU     = 2'd0;
  localparam logic [1:0] FW_PRIO   = 2'd0;
  localparam logic [3:0] SAT_8     = 4'd6;
  localparam logic [15:0] MAIN_68  = 16'd51;
`endif

  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_src1_used, dec_src2_used, dec_reg_wrt_en, dec_is_load;
  logic [3:0] dec_src1, dec_src2, dec_dst;
  logic flush, hold;

  logic        stall, sat_stall;
  logic [1:0]  fwd_sel1, fwd_sel2, sat_fwd1, sat_fwd2;
  logic [2:0]  inflight_valid, sat_inflight;
  logic [15:0] stall_count;
  logic [3:0]  sat_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ZERO_REG_HARDWIRED(1)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_dst(dec_dst), .dec_reg_wrt_en(dec_reg_wrt_en), .dec_is_load(dec_is_load),
    .flush(flush), .hold(hold), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .inflight_valid(inflight_valid), .stall_count(stall_count)
  );

  hazard_scoreboard #(.STALL_CNT_BITS(4)) dut_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_dst(dec_dst), .dec_reg_wrt_en(dec_reg_wrt_en), .dec_is_load(dec_is_load),
    .flush(flush), .hold(hold), .stall(sat_stall),
    .fwd_sel1(sat_fwd1), .fwd_sel2(sat_fwd2),
    .inflight_valid(sat_inflight), .stall_count(sat_count)
  );

  task automatic drive(input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic [3:0] d,
                       input logic w, input logic ld);
    dec_valid = v; dec_src1 = s1; dec_src1_used = u1; dec_src2 = s2; dec_src2_used = u2;
    dec_dst = d; dec_reg_wrt_en = w; dec_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);
    #2;
    checks++; if (inflight_valid !== 3'b000) begin errors++; $display("FAIL reset_inflight: got %b expected 000", inflight_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL reset_fwd1: got %0d expected 0", fwd_sel1); end
    idle();
    @(negedge clk) reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_raw_alu();
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_producer_stall: got %b expected 0", stall); end
    next_cycle();
    drive(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < N_RAW; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_%0d: got %b expected 1", i, stall); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", stall); end
    checks++; if (fwd_sel1 !== FW_RAW) begin errors++; $display("FAIL raw_fwd1: got %0d expected %0d", fwd_sel1, FW_RAW); end
    checks++; if (fwd_sel2 !== 2'd0) begin errors++; $display("FAIL raw_fwd2: got %0d expected 0", fwd_sel2); end
    next_cycle();
    exp_cnt += 16'(N_RAW);
    drain();
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL raw_count: got %0d expected %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < N_LU; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_%0d: got %b expected 1", i, stall); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", stall); end
    checks++; if (fwd_sel1 !== FW_LU) begin errors++; $display("FAIL lu_fwd1: got %0d expected %0d", fwd_sel1, FW_LU); end
    checks++; if (fwd_sel2 !== FW_LU) begin errors++; $display("FAIL lu_fwd2: got %0d expected %0d", fwd_sel2, FW_LU); end
    next_cycle();
    exp_cnt += 16'(N_LU);
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL lu_count: got %0d expected %0d", stall_count, exp_cnt); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    next_cycle();
    flush = 1'b0;
    idle();
    @(negedge clk);
    checks++; if (inflight_valid !== 3'b010) begin errors++; $display("FAIL flush_bubble: got %b expected 010", inflight_valid); end
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL flush_count: got %0d expected %0d", stall_count, exp_cnt); end
    next_cycle();
    drain();
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d: got %b expected 1", i, stall); end
      checks++; if (inflight_valid !== 3'b001) begin errors++; $display("FAIL hold_table_%0d: got %b expected 001", i, inflight_valid); end
      checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL hold_count_%0d: got %0d expected %0d", i, stall_count, exp_cnt); end
      next_cycle();
    end
    hold = 1'b0;
    for (int i = 0; i < N_LU; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_resume_stall_%0d: got %b expected 1", i, stall); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", stall); end
    checks++; if (fwd_sel1 !== FW_LU) begin errors++; $display("FAIL hold_fwd1: got %0d expected %0d", fwd_sel1, FW_LU); end
    next_cycle();
    exp_cnt += 16'(N_LU);
    drain();
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL hold_count_end: got %0d expected %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd10, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL zero_fwd1: got %0d expected 0", fwd_sel1); end
    checks++; if (fwd_sel2 !== 2'd0) begin errors++; $display("FAIL zero_fwd2: got %0d expected 0", fwd_sel2); end
    checks++; if (inflight_valid !== 3'b001) begin errors++; $display("FAIL zero_inflight: got %b expected 001", inflight_valid); end
    next_cycle();
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_invalid_dec: got %b expected 0", stall); end
    next_cycle();
    drive(1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 4'd11, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_unused_src: got %b expected 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL b2b_unused_fwd: got %0d expected 0", fwd_sel1); end
    next_cycle();
    drain();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_no_wrt: got %b expected 0", stall); end
    next_cycle();
    drain();
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (stall !== (N_PRIO != 0)) begin errors++; $display("FAIL b2b_prio_stall: got %b expected %0d", stall, N_PRIO); end
    checks++; if (fwd_sel1 !== FW_PRIO) begin errors++; $display("FAIL b2b_prio_fwd: got %0d expected %0d", fwd_sel1, FW_PRIO); end
    next_cycle();
    exp_cnt += 16'(N_PRIO);
    drain();
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_midrun_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (inflight_valid !== 3'b111) begin errors++; $display("FAIL mid_pre_inflight: got %b expected 111", inflight_valid); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b expected 1", stall); end
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL mid_pre_count: got %0d expected %0d", stall_count, exp_cnt); end
    #2 reset = 1'b0;
    #1;
    checks++; if (inflight_valid !== 3'b000) begin errors++; $display("FAIL mid_inflight: got %b expected 000", inflight_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", stall_count); end
    checks++; if (sat_count !== 4'd0) begin errors++; $display("FAIL mid_sat_count: got %0d expected 0", sat_count); end
    idle();
    @(negedge clk) reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_saturation();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
    repeat (8) next_cycle();
    checks++; if (sat_count !== SAT_8) begin errors++; $display("FAIL sat_partial: got %0d expected %0d", sat_count, SAT_8); end
    repeat (60) next_cycle();
    checks++; if (sat_count !== 4'hF) begin errors++; $display("FAIL sat_full: got %0h expected f", sat_count); end
    checks++; if (stall_count !== MAIN_68) begin errors++; $display("FAIL sat_main_count: got %0d expected %0d", stall_count, MAIN_68); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_alu();
    test_load_use();
    test_flush();
    test_hold();
    test_zero_reg();
    test_back_to_back();
    test_midrun_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised data-hazard unit for the pipelined CPU. It sits beside the DEC stage and tracks destination registers of in-flight instructions in EX..WB via a shift-register scoreboard. Each cycle it decides whether the instruction in DEC must stall and, when forwarding is compiled in, which stage supplies each source operand. It replaces the fixed-function staller and forwarding placeholders with one block sized by pipeline depth and register count.

Parameters:
REG_INDEX_BIT_WIDTH, 4, width of register indices.
PIPE_DEPTH, 3, number of tracked stages after DEC (entry 0 = EX, 1 = MEM, 2 = WB).
LOAD_READY_STAGE, 1, first entry index whose load result is forwardable.
ZERO_REG_HARDWIRED, 0, 1 = register 0 never causes a hazard.
STALL_CNT_BITS, 16, width of the stall-cycle counter.
FWD_SEL_BITS, 2, width of forward selects; must satisfy 2^FWD_SEL_BITS >= PIPE_DEPTH+1.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
dec_valid  in  1  DEC holds a real instruction
dec_src1 / dec_src2  in  REG_INDEX_BIT_WIDTH  source indices
dec_src1_used / dec_src2_used  in  1  source actually read
dec_dst  in  REG_INDEX_BIT_WIDTH  destination index
dec_reg_wrt_en  in  1  instruction writes the register file
dec_is_load  in  1  instruction is LW
flush  in  1  branch/JAL redirect; instruction in DEC is killed
hold  in  1  global freeze (e.g. memory wait)
stall  out  1  keep PC and IF/DEC buffer, inject bubble into EX
fwd_sel1 / fwd_sel2  out  FWD_SEL_BITS  0 = regfile, k+1 = entry k
inflight_valid  out  PIPE_DEPTH  per-entry valid bits, for debug
stall_count  out  STALL_CNT_BITS  saturating count of stall cycles

Behaviour:
- Entry fields: valid, dst, wrt, load. Entry k is "live" when valid and wrt are both set.
- Reset (reset=0, asynchronous): all entries invalid; stall_count=0. stall and fwd_sel are combinational and therefore read 0 after reset.
- Match rule (source s, entry k): s_used && live_k && dst_k==s, excluding s==0 when ZERO_REG_HARDWIRED=1.
- Stall (combinational):
  - Asserted when dec_valid && !flush && any blocking match exists.
  - A blocking match is defined under Optional Feature.
- Update on rising edge when hold=0:
  - Entries shift: entry k+1 <= entry k; entry PIPE_DEPTH-1 retires.
  - Entry 0 <= DEC instruction if dec_valid && !stall && !flush; otherwise a bubble (valid=0).
- hold=1: table frozen; stall_count does not increment; outputs still evaluated from current state.
- flush and stall simultaneous: flush wins; stall is forced 0; a bubble is inserted.
- WB (last entry): the regfile has no write-through, so a WB match is treated like any other stage.
- stall_count: increments on each edge with stall=1 && hold=0; saturates at all-ones.
- Latency: zero-cycle decision. A stalled instruction re-evaluates every cycle until clear.

Optional Feature:
Macro FORWARDING_EN.
- Defined: a match on entry k blocks only if load_k && k < LOAD_READY_STAGE. Otherwise fwd_sel = k+1 for the youngest (lowest k) matching entry, and 0 if there is no match. Load-use therefore costs 1 stall cycle at defaults.
- Undefined: every match blocks; fwd_sel outputs are tied to 0. A dependent instruction waits until its producer retires past WB.

Decomposition:
- Package hazard_pkg: scoreboard entry struct (valid, dst, wrt, load), FWD_SEL_REGFILE=0, helper function for the match rule.
- One natural sub-module: scoreboard_entry_match, the per-entry comparator producing match and block bits, instantiated PIPE_DEPTH×2.

Test Plan:
- Reset asserted mid-run with 3 live entries -> inflight_valid=000, stall=0, stall_count=0 immediately, without waiting for a clock edge.
- FORWARDING_EN: ADD r3 then SUB r4,r3,r1 -> stall=0, fwd_sel1=1 in cycle 2. Same case without the macro -> stall high for 3 cycles, then fwd_sel1=0.
- FORWARDING_EN: LW r5 then ADD r6,r5,r5 -> exactly 1 stall cycle, then fwd_sel1=fwd_sel2=2, stall_count=1.
- Flush with a dependent instruction in DEC -> stall=0, bubble inserted (inflight_valid[0]=0 next cycle), stall_count unchanged.
- hold=1 for 4 cycles during a load-use stall -> table unchanged, stall held, stall_count unchanged; resumes normally once hold=0.
- r0 dependency with ZERO_REG_HARDWIRED=1 -> no stall, fwd_sel=0. Force stalls past 65535 -> stall_count stays 0xFFFF.
